// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with DBIT data bits, optional parity and one or two stop bits.
// Latency: o_tx drops on the accepting edge. A frame lasts OS_TICK*(2+DBIT+par_en+two_stop) i_s_tick pulses.
// Flow control: o_busy is high for the whole frame. i_tx_start is ignored while busy and is not queued.
module uart_tx_cfg #(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic            i_s_tick,
  input  logic [DBIT-1:0] i_din,
  input  logic            i_par_en,
  input  logic            i_par_odd,
  input  logic            i_two_stop,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done_tick
);

  localparam int SW = $clog2(2 * OS_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_LAST1 = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] S_LAST2 = SW'(2 * OS_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_en_q, par_en_d;
  logic            par_odd_q, par_odd_d;
  logic            two_stop_q, two_stop_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  // Next-state logic. tx_d is loaded with the line level of the state being entered.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    p_d        = p_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          state_d    = START;
          b_d        = i_din;
          par_en_d   = i_par_en;
          par_odd_d  = i_par_odd;
          two_stop_d = i_two_stop;
          s_d        = '0;
          n_d        = '0;
          // Seeding with the odd flag makes the final XOR produce odd parity directly.
          p_d        = i_par_odd;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == S_LAST1) begin
            s_d     = '0;
            state_d = DATA;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_LAST1) begin
            s_d = '0;
            p_d = p_q ^ b_q[0];
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              if (par_en_q) begin
                state_d = PARITY;
                tx_d    = p_q ^ b_q[0];
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              n_d  = n_q + NW'(1);
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == S_LAST1) begin
            s_d     = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (i_s_tick) begin
          if (s_q == (two_stop_q ? S_LAST2 : S_LAST1)) begin
            s_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame in progress without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      p_q        <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      p_q        <= p_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_tx           = tx_q;
  assign o_busy         = (state_q != IDLE);
  assign o_tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit/16x instance and a 5-bit/4x instance, each checked every cycle
// against a tick-counting frame model, plus literal line-level and frame-length expectations.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, tick_a, pe_a, po_a, ts_a;
  logic [7:0] din_a;
  logic       tx_a, busy_a, done_a;
  logic       start_b, tick_b;
  logic [4:0] din_b;
  logic       tx_b, busy_b, done_b;
  logic       zero = 1'b0;

  uart_tx_cfg #(.DBIT(8), .OS_TICK(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start_a), .i_s_tick(tick_a), .i_din(din_a),
    .i_par_en(pe_a), .i_par_odd(po_a), .i_two_stop(ts_a),
    .o_tx(tx_a), .o_busy(busy_a), .o_tx_done_tick(done_a));

  uart_tx_cfg #(.DBIT(5), .OS_TICK(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start_b), .i_s_tick(tick_b), .i_din(din_b),
    .i_par_en(zero), .i_par_odd(zero), .i_two_stop(zero),
    .o_tx(tx_b), .o_busy(busy_b), .o_tx_done_tick(done_b));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a number of ticks; the line level follows from the tick index.
  typedef struct {
    bit       busy;
    bit       done;
    int       cnt;
    int       len;
    bit [8:0] din;
    bit       pe;
    bit       po;
  } model_t;

  model_t ma, mb;

  function automatic model_t mzero();
    model_t m;
    m.busy = 0; m.done = 0; m.cnt = 0; m.len = 0; m.din = '0; m.pe = 0; m.po = 0;
    return m;
  endfunction

  function automatic model_t mstep(input model_t m, input bit r, input bit st, input bit tk,
                                   input bit [8:0] d, input bit pe, input bit po, input bit ts,
                                   input int dbit, input int os);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (r) return mzero();
    if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.cnt  = 0;
        n.din  = d & 9'((1 << dbit) - 1);
        n.pe   = pe;
        n.po   = po;
        n.len  = os * (2 + dbit + int'(pe) + int'(ts));
      end
    end else if (tk) begin
      n.cnt = m.cnt + 1;
      if (n.cnt == m.len) begin
        n.busy = 1'b0;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic bit mlevel(input model_t m, input int dbit, input int os);
    int k;
    if (!m.busy) return 1'b1;
    k = m.cnt / os;
    if (k == 0) return 1'b0;
    if (k <= dbit) return m.din[k-1];
    if (k == dbit + 1 && m.pe) return (^m.din) ^ m.po;
    return 1'b1;
  endfunction

  initial begin
    ma = mzero();
    mb = mzero();
  end

  always @(posedge clk) begin
    ma = mstep(ma, rst, start_a, tick_a, {1'b0, din_a}, pe_a, po_a, ts_a, 8, 16);
    mb = mstep(mb, rst, start_b, tick_b, {4'b0, din_b}, 1'b0, 1'b0, 1'b0, 5, 4);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_tx",   int'(tx_a),   int'(mlevel(ma, 8, 16)));
      check("a_busy", int'(busy_a), int'(ma.busy));
      check("a_done", int'(done_a), int'(ma.done));
      check("b_tx",   int'(tx_b),   int'(mlevel(mb, 5, 4)));
      check("b_busy", int'(busy_b), int'(mb.busy));
      check("b_done", int'(done_b), int'(mb.done));
    end
  end

  // Line level per cycle after acceptance; lv[c] is the level following the c-th edge after accept.
  bit lv [0:599];
  int done_at;

  task automatic run_a(input logic [7:0] din, input logic pe, input logic po, input logic ts,
                       input logic [7:0] din2, input int pulse_at, input bit hold);
    @(negedge clk);
    din_a = din; pe_a = pe; po_a = po; ts_a = ts; start_a = 1'b1;
    done_at = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      lv[c]   = tx_a;
      din_a   = din2;
      pe_a    = ~pe;
      po_a    = ~po;
      ts_a    = ~ts;
      start_a = hold || (c + 1 == pulse_at);
      if (done_a) begin
        done_at = c;
        break;
      end
    end
    pe_a = pe; po_a = po; ts_a = ts;
  endtask

  task automatic run_b(input logic [4:0] din);
    @(negedge clk);
    din_b = din; start_b = 1'b1; tick_b = 1'b1;
    done_at = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      lv[c]   = tx_b;
      start_b = 1'b0;
      din_b   = ~din;
      tick_b  = ((c + 1) % 3 == 0);
      if (done_b) begin
        done_at = c;
        break;
      end
    end
    tick_b = 1'b0;
  endtask

  task automatic check_lv(input string name, input logic [15:0] exp, input int nb, input int per);
    for (int k = 0; k < nb; k++)
      check($sformatf("%s_bit%0d", name, k), int'(lv[per*k + per/2]), int'(exp[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c2;
    bit  got_done;
    rst = 1'b1; start_a = 0; tick_a = 1'b1; din_a = '0; pe_a = 0; po_a = 0; ts_a = 0;
    start_b = 0; tick_b = 0; din_b = '0;
    repeat (2) @(negedge clk);
    check("rst_tx",   int'(tx_a),   1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_b_tx", int'(tx_b),   1);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5
    run_a(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1, 1'b0);
    check("8n1_len", done_at, 160);
    check_lv("8n1", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16);
    check("8n1_busy_after", int'(busy_a), 0);
    check("8n1_start_first", int'(lv[0]), 0);
    check("8n1_start_last", int'(lv[15]), 0);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0
    run_a(8'h07, 1'b1, 1'b0, 1'b0, 8'hFF, -1, 1'b0);
    check("par_even_len", done_at, 176);
    check_lv("par_even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 16);
    run_a(8'h07, 1'b1, 1'b1, 1'b0, 8'h00, -1, 1'b0);
    check("par_odd_len", done_at, 176);
    check_lv("par_odd", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 16);

    // Two stop bits on 0x00
    run_a(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, -1, 1'b0);
    check("two_stop_len", done_at, 176);
    check("two_stop_last_data", int'(lv[143]), 0);
    check("two_stop_first", int'(lv[144]), 1);
    check("two_stop_last", int'(lv[175]), 1);

    // Start pulse with 0x3C during DATA is ignored
    run_a(8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 40, 1'b0);
    check("ignore_len", done_at, 160);
    check_lv("ignore", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16);

    // Start held through done: next frame starts the cycle after done
    run_a(8'h81, 1'b0, 1'b0, 1'b0, 8'h42, -1, 1'b1);
    check("b2b_len", done_at, 160);
    @(negedge clk);
    start_a = 1'b0;
    check("b2b_tx_low", int'(tx_a), 0);
    check("b2b_busy", int'(busy_a), 1);
    c2 = -1;
    for (int c = 1; c < 600; c++) begin
      @(negedge clk);
      if (done_a) begin
        c2 = c;
        break;
      end
    end
    check("b2b_second_len", c2, 160);

    // Reset during data bit 3, then a clean frame
    @(negedge clk);
    din_a = 8'hFF; pe_a = 0; po_a = 0; ts_a = 0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (70) @(negedge clk);
    check("pre_rst_busy", int'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx", int'(tx_a), 1);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    got_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) got_done = 1'b1;
    end
    check("mid_rst_no_done", int'(got_done), 0);
    run_a(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, -1, 1'b0);
    check("post_rst_len", done_at, 160);
    check_lv("post_rst", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 16);

    // Small instance: DBIT=5, OS_TICK=4, tick every third cycle, 0x15
    run_b(5'h15);
    check("small_len", done_at, 84);
    for (int k = 0; k < 7; k++) begin
      logic [6:0] expb;
      expb = {1'b1, 5'h15, 1'b0};
      check($sformatf("small_bit%0d_first", k), int'(lv[12*k]),      int'(expb[k]));
      check($sformatf("small_bit%0d_last", k),  int'(lv[12*k + 11]), int'(expb[k]));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
